// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: sends an (N+1)-bit word MSB first, one bit per DIV clocks,
// with a shift strobe per bit and a frame-complete strobe for a downstream SIPO.
//
// state | meaning
// IDLE  | waiting for din_valid; din_ready high, shift register empty
// SHIFT | bits in flight; divider paces bit_en, bit counter tracks position
// DONE  | one-cycle soc strobe after the last bit has been shifted out
module serial_frame_tx #(
  parameter int N   = 7,
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [N:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       SO,
  output logic       bit_en,
  output logic       soc,
  output logic       busy
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(N + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [N:0]    sreg;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    bit_en    = 1'b0;
    soc       = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (div_cnt == DIV_LAST) begin
          bit_en = 1'b1;
          if (bit_cnt == BIT_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        soc       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Zero fill on each shift leaves the register empty by DONE, so SO is 0 outside SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sreg    <= din;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      if (bit_en) begin
        sreg    <= {sreg[N-1:0], 1'b0};
        div_cnt <= '0;
        if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign SO = sreg[N];

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a DIV=4 and a DIV=1 instance, each feeding a small SIPO model.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din0 = '0, din1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       rdy0, so0, be0, soc0, busy0;
  logic       rdy1, so1, be1, soc1, busy1;
  logic       sel = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.N(7), .DIV(4)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .din_valid(v0), .din_ready(rdy0),
    .SO(so0), .bit_en(be0), .soc(soc0), .busy(busy0));

  serial_frame_tx #(.N(7), .DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(v1), .din_ready(rdy1),
    .SO(so1), .bit_en(be1), .soc(soc1), .busy(busy1));

  logic [7:0] sh0, sh1, pd0, pd1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0 <= '0; sh1 <= '0; pd0 <= '0; pd1 <= '0;
    end else begin
      if (be0)  sh0 <= {sh0[6:0], so0};
      if (soc0) pd0 <= sh0;
      if (be1)  sh1 <= {sh1[6:0], so1};
      if (soc1) pd1 <= sh1;
    end
  end

  wire       rdy_m  = sel ? rdy1  : rdy0;
  wire       so_m   = sel ? so1   : so0;
  wire       be_m   = sel ? be1   : be0;
  wire       soc_m  = sel ? soc1  : soc0;
  wire       busy_m = sel ? busy1 : busy0;
  wire [7:0] pd_m   = sel ? pd1   : pd0;

  task automatic chk(input string tag, input string what, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s cyc %0d actual %0h required %0h", tag, what, cyc, act, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] w, input logic vld);
    if (sel) begin din1 = w; v1 = vld; end
    else     begin din0 = w; v0 = vld; end
  endtask

  task automatic chk_idle(input string tag, input int cyc);
    chk(tag, "so", cyc, so_m, 0);
    chk(tag, "bit_en", cyc, be_m, 0);
    chk(tag, "soc", cyc, soc_m, 0);
    chk(tag, "busy", cyc, busy_m, 0);
    chk(tag, "din_ready", cyc, rdy_m, 1);
  endtask

  // Entered just after a rising edge with the DUT idle; returns just after the edge that ends
  // the soc cycle, i.e. at the start of cycle 8*dv+2 where din_ready is back.
  task automatic frame(input logic [7:0] w, input int dv, input logic [7:0] dd,
                       input logic dvld, input logic [7:0] exp_pd, input string tag);
    int last;
    logic exp_be, exp_so;
    last = 8 * dv;
    set_in(w, 1'b1);
    @(negedge clk);
    chk(tag, "ready_at_accept", 0, rdy_m, 1);
    chk(tag, "busy_at_accept", 0, busy_m, 0);
    @(posedge clk); #1;
    set_in(dd, dvld);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      exp_be = ((c % dv) == 0) && (c <= last);
      exp_so = (c <= last) ? w[7 - (c - 1) / dv] : 1'b0;
      chk(tag, "bit_en", c, be_m, exp_be);
      chk(tag, "so", c, so_m, exp_so);
      chk(tag, "soc", c, soc_m, (c == last + 1));
      chk(tag, "busy", c, busy_m, 1);
      chk(tag, "din_ready", c, rdy_m, 0);
      @(posedge clk); #1;
    end
    chk(tag, "pdata", last + 2, pd_m, exp_pd);
  endtask

  typedef struct {
    logic [7:0] w;
    logic       s;
    int         dv;
    logic [7:0] dd;
    logic       dvld;
    logic [7:0] exp_pd;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 4, 8'h3C, 1'b1, 8'hA5};
    tbl[1] = '{8'h01, 1'b0, 4, 8'h00, 1'b0, 8'h01};
    tbl[2] = '{8'h80, 1'b0, 4, 8'hFF, 1'b1, 8'h80};
    tbl[3] = '{8'h5A, 1'b1, 1, 8'h00, 1'b0, 8'h5A};
    tbl[4] = '{8'hC3, 1'b1, 1, 8'h3C, 1'b1, 8'hC3};

    // Reset held with din_valid toggling on both instances
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      v0 = i[0]; v1 = ~i[0]; din0 = 8'hFF; din1 = 8'hFF;
      sel = i[1];
      @(negedge clk);
      chk_idle("reset_hold", i);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sel = 1'b0; set_in(8'h00, 1'b0);
    sel = 1'b1; set_in(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sel = i[0];
      @(negedge clk);
      chk_idle("reset_release", i);
      @(posedge clk); #1;
    end

    for (int k = 0; k < 5; k++) begin
      sel = tbl[k].s;
      frame(tbl[k].w, tbl[k].dv, tbl[k].dd, tbl[k].dvld, tbl[k].exp_pd, $sformatf("vec%0d", k));
      set_in(8'h00, 1'b0);
      @(negedge clk);
      chk_idle($sformatf("vec%0d_after", k), 0);
      @(posedge clk); #1;
    end

    // Back-to-back frames with din_valid held high throughout
    sel = 1'b0;
    frame(8'hFF, 4, 8'h00, 1'b1, 8'hFF, "b2b_ff");
    frame(8'h00, 4, 8'h00, 1'b0, 8'h00, "b2b_00");
    @(negedge clk);
    chk_idle("b2b_after", 0);
    @(posedge clk); #1;

    // Reset pulsed right after the 3rd bit_en of a frame
    sel = 1'b0;
    set_in(8'hFF, 1'b1);
    @(posedge clk); #1;
    set_in(8'h00, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("abort", "bit_en", c, be_m, ((c % 4) == 0));
      @(posedge clk); #1;
    end
    chk("abort", "so_before_reset", 13, so_m, 1);
    rst_n = 1'b0;
    #1;
    chk_idle("abort_async", 13);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("abort_hold", i);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("abort_release", i);
      @(posedge clk); #1;
    end
    frame(8'h81, 4, 8'h00, 1'b0, 8'h81, "after_abort");
    @(negedge clk);
    chk_idle("after_abort_idle", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
